choreo_input_controller: RTL and testbench

Front-panel control stage directly upstream of the LED pattern generator. It synchronises and debounces four raw push-buttons and turns presses into the generator's control inputs: pattern select, speed select and pause. It adds an optional auto-advance mode that steps through the patterns on a timer. All outputs are registered and connect straight to the generator's `pat_sel`, `speed_sel` and `pause` inputs.

---
 rtl/choreo_input_controller.sv | 123 ++++++++++++
 tb/tb_choreo_input_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/choreo_input_controller.sv
// rtl/choreo_input_controller.sv - button synchronise/debounce and pattern control for the LED generator
module choreo_input_controller #(
  parameter int DB_CYCLES   = 16,
  parameter int AUTO_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_next,
  input  logic       btn_speed,
  input  logic       btn_pause,
  input  logic       btn_auto,
  output logic [2:0] pat_sel,
  output logic       speed_sel,
  output logic       pause,
  output logic       auto_mode,
  output logic       pat_change
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int AW = $clog2(AUTO_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);

  // Button lanes: 0 = next, 1 = speed, 2 = pause, 3 = auto
  logic [3:0]          w_btn;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_db;
  logic [3:0][DW-1:0]  r_cnt;
  logic [3:0]          w_press;
  logic [3:0]          w_act;

  logic [AW-1:0]       r_timer;
  logic [2:0]          r_pat_sel;
  logic                r_speed_sel;
  logic                r_pause;
  logic                r_auto_mode;
  logic                r_pat_change;
  logic                w_tick;
  logic                w_wrap;
  logic                w_step;
  logic [2:0]          w_pat_nxt;

  assign w_btn = {btn_auto, btn_pause, btn_speed, btn_next};

  // Two-flop synchronisers and saturating-count debouncers, free running regardless of ena
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press event is the 0->1 flip of the debounced level, consumed on the same edge
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 4; i++) begin
      w_press[i] = r_sync2[i] & ~r_db[i] & (r_cnt[i] == DB_MAX);
    end
  end

  assign w_act  = w_press & {4{ena}};
  assign w_tick = ena & r_auto_mode & ~r_pause;
  assign w_wrap = w_tick & (r_timer == AUTO_MAX);
  // An auto press on the wrap edge can only be turning auto off, so it cancels the step
  assign w_step = w_wrap & ~w_act[3];

  // Next pattern: manual advance wraps 7->0 and wins over an auto step; auto skips pattern 7
  always_comb begin
    w_pat_nxt = r_pat_sel;
    if (w_act[0]) begin
      w_pat_nxt = r_pat_sel + 3'd1;
    end else if (w_step) begin
      w_pat_nxt = (r_pat_sel >= 3'd6) ? 3'd0 : r_pat_sel + 3'd1;
    end
  end

  // Control registers, auto timer and pattern-change strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= '0;
      r_pat_sel    <= '0;
      r_speed_sel  <= 1'b0;
      r_pause      <= 1'b0;
      r_auto_mode  <= 1'b0;
      r_pat_change <= 1'b0;
    end else begin
      if (w_act[0] | w_act[3]) begin
        r_timer <= '0;
      end else if (w_tick) begin
        r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      end
      r_pat_sel    <= w_pat_nxt;
      r_pat_change <= (w_pat_nxt != r_pat_sel);
      r_speed_sel  <= r_speed_sel ^ w_act[1];
      r_pause      <= r_pause ^ w_act[2];
      r_auto_mode  <= r_auto_mode ^ w_act[3];
    end
  end

  assign pat_sel    = r_pat_sel;
  assign speed_sel  = r_speed_sel;
  assign pause      = r_pause;
  assign auto_mode  = r_auto_mode;
  assign pat_change = r_pat_change;

endmodule

// File: tb/tb_choreo_input_controller.sv
// tb/tb_choreo_input_controller.sv - directed self-checking bench for choreo_input_controller
module tb_choreo_input_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       btn_next;
  logic       btn_speed;
  logic       btn_pause;
  logic       btn_auto;
  logic [2:0] pat_sel;
  logic       speed_sel;
  logic       pause;
  logic       auto_mode;
  logic       pat_change;

  int n_checks = 0;
  int n_errors = 0;
  int pc_count = 0;

  choreo_input_controller #(
    .DB_CYCLES  (4),
    .AUTO_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .btn_next  (btn_next),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .btn_auto  (btn_auto),
    .pat_sel   (pat_sel),
    .speed_sel (speed_sel),
    .pause     (pause),
    .auto_mode (auto_mode),
    .pat_change(pat_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pat_change) pc_count++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_next  = v;
      1: btn_speed = v;
      2: btn_pause = v;
      default: btn_auto = v;
    endcase
  endtask

  // Clean press: held long enough to register, then released and allowed to settle
  task automatic press(input int b);
    set_btn(b, 1'b1);
    ticks(6);
    set_btn(b, 1'b0);
    ticks(8);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1;
    btn_next = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0; btn_auto = 1'b0;
    ticks(3);
    check("rst_pat", 32'(pat_sel), 0);
    check("rst_speed", 32'(speed_sel), 0);
    check("rst_pause", 32'(pause), 0);
    check("rst_auto", 32'(auto_mode), 0);
    check("rst_pchg", 32'(pat_change), 0);
    rst = 1'b0;

    // Idle after reset
    pc_count = 0;
    ticks(100);
    check("idle_pchg_cnt", 32'(pc_count), 0);
    check("idle_pat", 32'(pat_sel), 0);
    check("idle_flags", {29'd0, speed_sel, pause, auto_mode}, 0);

    // Manual advance with wrap, landing on edge 6 of each press
    for (int k = 1; k <= 8; k++) begin
      btn_next = 1'b1;
      ticks(5);
      check("man_pre", 32'(pat_sel), 32'((k - 1) % 8));
      tick();
      check("man_post", 32'(pat_sel), 32'(k % 8));
      check("man_pchg_hi", 32'(pat_change), 1);
      tick();
      check("man_pchg_lo", 32'(pat_change), 0);
      btn_next = 1'b0;
      ticks(8);
    end

    // Short raw pulse is filtered
    pc_count = 0;
    btn_next = 1'b1;
    ticks(3);
    btn_next = 1'b0;
    ticks(12);
    check("short_pat", 32'(pat_sel), 0);
    check("short_pchg", 32'(pc_count), 0);

    // Bouncing pause button then steady high
    for (int i = 0; i < 5; i++) begin
      btn_pause = 1'b1; ticks(2);
      btn_pause = 1'b0; ticks(2);
    end
    check("bounce_none", 32'(pause), 0);
    btn_pause = 1'b1;
    ticks(5);
    check("bounce_pre", 32'(pause), 0);
    tick();
    check("bounce_post", 32'(pause), 1);
    ticks(20);
    check("bounce_hold", 32'(pause), 1);
    btn_pause = 1'b0;
    ticks(10);
    check("bounce_release", 32'(pause), 1);
    press(2);
    check("unpause", 32'(pause), 0);

    // Auto mode from pattern 5
    for (int i = 0; i < 5; i++) press(0);
    check("auto_start_pat", 32'(pat_sel), 5);
    btn_auto = 1'b1;
    ticks(6);
    check("auto_on", 32'(auto_mode), 1);
    btn_auto = 1'b0;
    ticks(7); check("auto_s1_pre", 32'(pat_sel), 5);
    tick();   check("auto_s1", 32'(pat_sel), 6);
    check("auto_s1_pchg", 32'(pat_change), 1);
    ticks(7); check("auto_s2_pre", 32'(pat_sel), 6);
    tick();   check("auto_s2_skip7", 32'(pat_sel), 0);
    ticks(7); check("auto_s3_pre", 32'(pat_sel), 0);
    tick();   check("auto_s3", 32'(pat_sel), 1);

    // Pause freezes timer at 6, resume steps two edges later
    btn_pause = 1'b1;
    ticks(6);
    check("apause_on", 32'(pause), 1);
    check("apause_pat", 32'(pat_sel), 1);
    btn_pause = 1'b0;
    pc_count = 0;
    ticks(50);
    check("apause_hold_pat", 32'(pat_sel), 1);
    check("apause_hold_pchg", 32'(pc_count), 0);
    btn_pause = 1'b1;
    ticks(6);
    check("aresume_off", 32'(pause), 0);
    check("aresume_pat0", 32'(pat_sel), 1);
    btn_pause = 1'b0;
    tick(); check("aresume_pat1", 32'(pat_sel), 1);
    tick(); check("aresume_step", 32'(pat_sel), 2);

    // Next press on the auto-step edge advances once and restarts the period
    ticks(2);
    btn_next = 1'b1;
    ticks(6);
    check("coinc_pat", 32'(pat_sel), 3);
    check("coinc_pchg", 32'(pat_change), 1);
    btn_next = 1'b0;
    ticks(7); check("coinc_next_pre", 32'(pat_sel), 3);
    tick();   check("coinc_next_step", 32'(pat_sel), 4);

    // Speed press with ena low is lost; outputs and timer hold
    ena = 1'b0;
    btn_speed = 1'b1;
    ticks(10);
    check("ena0_speed", 32'(speed_sel), 0);
    check("ena0_pat", 32'(pat_sel), 4);
    btn_speed = 1'b0;
    ticks(10);
    check("ena0_speed_after", 32'(speed_sel), 0);
    ena = 1'b1;
    press(1);
    check("ena1_speed", 32'(speed_sel), 1);

    // Asynchronous reset mid-debounce, button held through release
    btn_next = 1'b1;
    ticks(3);
    rst = 1'b1;
    #1;
    check("arst_pat", 32'(pat_sel), 0);
    check("arst_flags", {29'd0, speed_sel, pause, auto_mode}, 0);
    check("arst_pchg", 32'(pat_change), 0);
    ticks(3);
    rst = 1'b0;
    ticks(5);
    check("held_pre", 32'(pat_sel), 0);
    tick();
    check("held_press", 32'(pat_sel), 1);
    btn_next = 1'b0;
    ticks(10);
    check("held_once", 32'(pat_sel), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
